pet_needs_engine: RTL and testbench

Responder side of the care-request handshake for the virtual pet. Consumes the one-cycle "button held 5 s" request pulses for food and medicine, runs the corresponding care action for a fixed time while asserting the matching `activo_*` busy flag back to the button/mode logic, and maintains two 2-bit need levels that rise on care and decay over time. Also packs its state into the 16-bit four-nibble word consumed by the seven-segment multiplexer.

---
 rtl/pet_needs_engine.sv | 126 ++++++++++++
 tb/tb_pet_needs_engine.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pet_needs_engine.sv
// rtl/pet_needs_engine.sv - care-request responder: FEED/HEAL actions, need levels, display word
// Optional decay of need levels is built only when PET_NEEDS_DECAY_EN is defined.
module pet_needs_engine #(
  parameter int ACTIVE_CYCLES = 50_000_000,
  parameter int DECAY_CYCLES  = 500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_comida,
  input  logic        req_medicina,
  output logic        activo_comida,
  output logic        activo_medicina,
  output logic [1:0]  nivel_comida,
  output logic [1:0]  nivel_medicina,
  output logic [15:0] num
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    HEAL = 2'd2
  } state_t;

  localparam int AW = $clog2(ACTIVE_CYCLES);
  localparam logic [AW-1:0] ACT_LAST = AW'(ACTIVE_CYCLES - 1);

  state_t        state, state_next;
  logic [AW-1:0] act_cnt, act_next;
  logic [1:0]    food_next, med_next;
  logic          inc_food, inc_med;
  logic          decay_tick;
  logic [15:0]   num_next;

`ifdef PET_NEEDS_DECAY_EN
  localparam int DW = $clog2(DECAY_CYCLES);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_CYCLES - 1);

  logic [DW-1:0] decay_cnt;

  assign decay_tick = (decay_cnt == DECAY_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      decay_cnt <= '0;
    end else if (decay_tick) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + DW'(1);
    end
  end
`else
  // DECAY_CYCLES is a non-negative int, so this is a constant zero: levels never decay.
  assign decay_tick = (DECAY_CYCLES < 0);
`endif

  always_comb begin
    state_next = state;
    act_next   = act_cnt + AW'(1);
    inc_food   = 1'b0;
    inc_med    = 1'b0;
    case (state)
      IDLE: begin
        act_next = '0;
        // Food has priority; a simultaneous medicine request is dropped.
        if (req_comida) begin
          state_next = FEED;
          inc_food   = 1'b1;
        end else if (req_medicina) begin
          state_next = HEAL;
          inc_med    = 1'b1;
        end
      end
      FEED, HEAL: begin
        if (act_cnt == ACT_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        act_next   = '0;
      end
    endcase
  end

  // An increment on a tick suppresses decay for that level only.
  always_comb begin
    food_next = nivel_comida;
    med_next  = nivel_medicina;
    if (inc_food) begin
      if (nivel_comida != 2'd3) food_next = nivel_comida + 2'd1;
    end else if (decay_tick && nivel_comida != 2'd0) begin
      food_next = nivel_comida - 2'd1;
    end
    if (inc_med) begin
      if (nivel_medicina != 2'd3) med_next = nivel_medicina + 2'd1;
    end else if (decay_tick && nivel_medicina != 2'd0) begin
      med_next = nivel_medicina - 2'd1;
    end
  end

  always_comb begin
    num_next = {2'b00, state_next, 2'b00, food_next, 2'b00, med_next,
                ((food_next == 2'd0) || (med_next == 2'd0)) ? 4'hF : 4'h0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      act_cnt         <= '0;
      nivel_comida    <= 2'd3;
      nivel_medicina  <= 2'd3;
      activo_comida   <= 1'b0;
      activo_medicina <= 1'b0;
      num             <= 16'h0330;
    end else begin
      state           <= state_next;
      act_cnt         <= act_next;
      nivel_comida    <= food_next;
      nivel_medicina  <= med_next;
      activo_comida   <= (state_next == FEED);
      activo_medicina <= (state_next == HEAL);
      num             <= num_next;
    end
  end

endmodule

// File: tb/tb_pet_needs_engine.sv
// tb/tb_pet_needs_engine.sv - directed bench for pet_needs_engine (ACTIVE_CYCLES=4, DECAY_CYCLES=10)
module tb_pet_needs_engine;

  logic        clk;
  logic        reset;
  logic        req_comida;
  logic        req_medicina;
  logic        activo_comida;
  logic        activo_medicina;
  logic [1:0]  nivel_comida;
  logic [1:0]  nivel_medicina;
  logic [15:0] num;

  int checks = 0;
  int errors = 0;

  pet_needs_engine #(
    .ACTIVE_CYCLES(4),
    .DECAY_CYCLES (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_comida     (req_comida),
    .req_medicina   (req_medicina),
    .activo_comida  (activo_comida),
    .activo_medicina(activo_medicina),
    .nivel_comida   (nivel_comida),
    .nivel_medicina (nivel_medicina),
    .num            (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_comida   = 1'b0;
    req_medicina = 1'b0;
    step();
    chk("reset_num", num, 16'h0330);
    chk("reset_activo_comida", 16'(activo_comida), 16'h0);
    chk("reset_activo_medicina", 16'(activo_medicina), 16'h0);
    chk("reset_levels", 16'({nivel_comida, nivel_medicina}), 16'hF);
    reset = 1'b0;

`ifdef PET_NEEDS_DECAY_EN
    repeat (9) step();
    chk("pre_tick_num", num, 16'h0330);
    step();
    chk("first_tick_num", num, 16'h0220);
    chk("first_tick_comida", 16'(nivel_comida), 16'h2);
    chk("first_tick_medicina", 16'(nivel_medicina), 16'h2);
`else
    repeat (100) step();
    chk("no_decay_num", num, 16'h0330);
`endif

    req_comida = 1'b1;
    step();
    req_comida = 1'b0;
    chk("feed_activo", 16'(activo_comida), 16'h1);
`ifdef PET_NEEDS_DECAY_EN
    chk("feed_num", num, 16'h1320);
`else
    chk("feed_num", num, 16'h1330);
`endif
    step();
    chk("feed_c2_activo", 16'(activo_comida), 16'h1);
    req_medicina = 1'b1;
    step();
    req_medicina = 1'b0;
    chk("feed_c3_activo", 16'(activo_comida), 16'h1);
    chk("feed_med_ignored", 16'(activo_medicina), 16'h0);
    step();
    chk("feed_c4_activo", 16'(activo_comida), 16'h1);
    step();
    chk("feed_end_activo", 16'(activo_comida), 16'h0);
    chk("no_heal_after_feed", 16'(activo_medicina), 16'h0);
`ifdef PET_NEEDS_DECAY_EN
    chk("feed_end_num", num, 16'h0320);
`else
    chk("feed_end_num", num, 16'h0330);
`endif

    req_comida   = 1'b1;
    req_medicina = 1'b1;
    step();
    req_comida   = 1'b0;
    req_medicina = 1'b0;
    chk("both_activo_comida", 16'(activo_comida), 16'h1);
    chk("both_activo_medicina", 16'(activo_medicina), 16'h0);
`ifdef PET_NEEDS_DECAY_EN
    chk("both_num", num, 16'h1320);
`else
    chk("both_num", num, 16'h1330);
`endif
    repeat (3) step();
    chk("both_c4_activo_comida", 16'(activo_comida), 16'h1);
    chk("both_c4_activo_medicina", 16'(activo_medicina), 16'h0);
    step();
    chk("both_end_activo_comida", 16'(activo_comida), 16'h0);
`ifdef PET_NEEDS_DECAY_EN
    chk("tick2_num", num, 16'h0210);
    repeat (10) step();
    chk("tick3_num", num, 16'h010F);
    repeat (10) step();
    chk("tick4_num", num, 16'h000F);
    repeat (9) step();
    req_medicina = 1'b1;
    step();
    req_medicina = 1'b0;
    chk("heal_on_tick_num", num, 16'h201F);
    chk("heal_on_tick_medicina", 16'(nivel_medicina), 16'h1);
    chk("heal_on_tick_comida", 16'(nivel_comida), 16'h0);
`else
    chk("both_end_num", num, 16'h0330);
    req_medicina = 1'b1;
    step();
    req_medicina = 1'b0;
    chk("heal_num", num, 16'h2330);
`endif
    chk("heal_activo", 16'(activo_medicina), 16'h1);
    step();
    chk("heal_c2_activo", 16'(activo_medicina), 16'h1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_activo_medicina", 16'(activo_medicina), 16'h0);
    chk("abort_num", num, 16'h0330);
    chk("abort_levels", 16'({nivel_comida, nivel_medicina}), 16'hF);

`ifdef PET_NEEDS_DECAY_EN
    repeat (9) step();
    chk("restart_pre_tick_num", num, 16'h0330);
    step();
    chk("restart_tick_num", num, 16'h0220);
`else
    repeat (100) step();
    chk("idle100_num", num, 16'h0330);
    chk("idle100_levels", 16'({nivel_comida, nivel_medicina}), 16'hF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
